// File: rtl/vadd_lane_alu_pipe.sv
// Lane ALU stage for the Vadd datapath: per-packet op latch, two-stage compute, credit-managed FWFT FIFO.
// Optional build macro VADD_LANE_ALU_SAT_EN enables unsigned per-lane saturation and stat_sat_events.
module vadd_lane_alu_pipe #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LANE_WIDTH       = 32,
  parameter int C_FIFO_DEPTH       = 32,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [C_LANE_WIDTH-1:0]         ctrl_constant,
  input  logic [1:0]                      ctrl_op,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_CNT_WIDTH-1:0]          stat_beats,
  output logic [C_CNT_WIDTH-1:0]          stat_packets,
`ifdef VADD_LANE_ALU_SAT_EN
  output logic [C_CNT_WIDTH-1:0]          stat_sat_events,
`endif
  output logic                            busy
);
  localparam int DW    = C_AXIS_TDATA_WIDTH;
  localparam int KW    = DW / 8;
  localparam int LW    = C_LANE_WIDTH;
  localparam int LANES = DW / LW;
  localparam int EW    = DW + KW + 1;
  localparam int AW    = $clog2(C_FIFO_DEPTH);
  localparam int OW    = AW + 2;

  // Valid/ready: a beat moves only on a rising edge where valid and ready are both high;
  // the sender holds its payload stable until then, and ready never depends on valid.
  logic                s_acc, m_hs;
  logic                ready_q, ready_d;
  logic                start_q;
  logic [1:0]          op_q, eff_op;
  logic [LW-1:0]       const_q, eff_const;
  logic                s1_valid_q, s1_last_q;
  logic [DW-1:0]       s1_data_q;
  logic [KW-1:0]       s1_keep_q;
  logic [1:0]          s1_op_q;
  logic [LW-1:0]       s1_const_q;
  logic                s2_valid_q;
  logic [EW-1:0]       s2_beat_q;
  logic [DW-1:0]       lane_res;
  logic [EW-1:0]       mem [C_FIFO_DEPTH];
  logic [EW-1:0]       rd_beat;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic [OW-1:0]       occ;
  logic [C_CNT_WIDTH-1:0] beats_q, packets_q;

  assign s_acc     = s_axis_tvalid & ready_q;
  assign m_axis_tvalid = (count_q != '0);
  assign m_hs      = m_axis_tvalid & m_axis_tready;
  assign eff_op    = start_q ? ctrl_op : op_q;
  assign eff_const = start_q ? ctrl_constant : const_q;

  // Conservative credit: reads this cycle are not subtracted, so the FIFO can never overflow.
  assign occ     = OW'(count_q) + OW'(s1_valid_q) + OW'(s2_valid_q) + OW'(s_acc);
  assign ready_d = (occ <= OW'(C_FIFO_DEPTH - 3));

  always_comb begin
    count_d = count_q;
    case ({s2_valid_q, m_hs})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef VADD_LANE_ALU_SAT_EN
  logic [LW:0]            wide;
  logic                   sat_any;
  logic [C_CNT_WIDTH-1:0] sat_q;

  always_comb begin
    lane_res = '0;
    sat_any  = 1'b0;
    wide     = '0;
    for (int l = 0; l < LANES; l++) begin
      case (s1_op_q)
        2'b00:   wide = {1'b0, s1_data_q[l*LW +: LW]} + {1'b0, s1_const_q};
        2'b01:   wide = {1'b0, s1_data_q[l*LW +: LW]} - {1'b0, s1_const_q};
        2'b10:   wide = {1'b0, s1_data_q[l*LW +: LW]};
        default: wide = {1'b0, s1_const_q} - {1'b0, s1_data_q[l*LW +: LW]};
      endcase
      // Top bit is carry for add and borrow for the subtractions.
      if (wide[LW]) begin
        lane_res[l*LW +: LW] = (s1_op_q == 2'b00) ? '1 : '0;
        sat_any = 1'b1;
      end else begin
        lane_res[l*LW +: LW] = wide[LW-1:0];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                    sat_q <= '0;
    else if (s1_valid_q & sat_any) sat_q <= sat_q + C_CNT_WIDTH'(1);
  end
  assign stat_sat_events = sat_q;
`else
  always_comb begin
    lane_res = '0;
    for (int l = 0; l < LANES; l++) begin
      case (s1_op_q)
        2'b00:   lane_res[l*LW +: LW] = s1_data_q[l*LW +: LW] + s1_const_q;
        2'b01:   lane_res[l*LW +: LW] = s1_data_q[l*LW +: LW] - s1_const_q;
        2'b10:   lane_res[l*LW +: LW] = s1_data_q[l*LW +: LW];
        default: lane_res[l*LW +: LW] = s1_const_q - s1_data_q[l*LW +: LW];
      endcase
    end
  end
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ready_q    <= 1'b0;
      start_q    <= 1'b1;
      op_q       <= '0;
      const_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_keep_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_op_q    <= '0;
      s1_const_q <= '0;
      s2_valid_q <= 1'b0;
      s2_beat_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beats_q    <= '0;
      packets_q  <= '0;
    end else begin
      ready_q    <= ready_d;
      s1_valid_q <= s_acc;
      s1_data_q  <= s_axis_tdata;
      s1_keep_q  <= s_axis_tkeep;
      s1_last_q  <= s_axis_tlast;
      s1_op_q    <= eff_op;
      s1_const_q <= eff_const;
      s2_valid_q <= s1_valid_q;
      s2_beat_q  <= {s1_last_q, s1_keep_q, lane_res};
      count_q    <= count_d;
      if (s_acc) begin
        op_q    <= eff_op;
        const_q <= eff_const;
        start_q <= s_axis_tlast;
        beats_q <= beats_q + C_CNT_WIDTH'(1);
      end
      if (s2_valid_q) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (m_hs) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        if (rd_beat[EW-1]) packets_q <= packets_q + C_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (s2_valid_q) mem[wr_ptr_q] <= s2_beat_q;
  end

  assign rd_beat       = mem[rd_ptr_q];
  assign m_axis_tdata  = m_axis_tvalid ? rd_beat[DW-1:0] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? rd_beat[DW +: KW] : '0;
  assign m_axis_tlast  = m_axis_tvalid & rd_beat[EW-1];
  assign s_axis_tready = ready_q;
  assign stat_beats    = beats_q;
  assign stat_packets  = packets_q;
  assign busy          = s1_valid_q | s2_valid_q | m_axis_tvalid;
endmodule

// File: tb/tb_vadd_lane_alu_pipe.sv
// Self-checking bench for vadd_lane_alu_pipe: randomized beats against a packet-level lane model.
// Builds with or without VADD_LANE_ALU_SAT_EN.
module tb_vadd_lane_alu_pipe;
  localparam int DW = 512, LW = 32, LANES = 16, KW = 64, DEPTH = 32, CW = 32;
  localparam int EW = DW + KW + 1;

  logic          aclk = 1'b0;
  logic          areset;
  logic [LW-1:0] ctrl_constant;
  logic [1:0]    ctrl_op;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [CW-1:0] stat_beats, stat_packets;
  logic          busy;
`ifdef VADD_LANE_ALU_SAT_EN
  logic [CW-1:0] stat_sat_events;
`endif

  int checks = 0;
  int passed = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  logic          tb_start;
  logic [1:0]    tb_op;
  logic [LW-1:0] tb_c;

  always #5 aclk = ~aclk;

  vadd_lane_alu_pipe dut (
    .aclk(aclk), .areset(areset),
    .ctrl_constant(ctrl_constant), .ctrl_op(ctrl_op),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .stat_beats(stat_beats), .stat_packets(stat_packets),
`ifdef VADD_LANE_ALU_SAT_EN
    .stat_sat_events(stat_sat_events),
`endif
    .busy(busy)
  );

  // Reference lane arithmetic on 64-bit integers, folded back into 32 bits.
  function automatic logic [LW-1:0] ref_lane(input logic [1:0] op, input logic [LW-1:0] c,
                                             input logic [LW-1:0] a);
    longint unsigned x, y, m, r;
    m = 64'h1_0000_0000;
    x = a;
    y = c;
`ifdef VADD_LANE_ALU_SAT_EN
    case (op)
      2'd0:    r = (x + y >= m) ? m - 1 : x + y;
      2'd1:    r = (x >= y) ? x - y : 0;
      2'd2:    r = x;
      default: r = (y >= x) ? y - x : 0;
    endcase
`else
    case (op)
      2'd0:    r = (x + y) % m;
      2'd1:    r = (x + m - y) % m;
      2'd2:    r = x;
      default: r = (y + m - x) % m;
    endcase
`endif
    return r[LW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*LW +: LW] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] ramp_data(input int base);
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*LW +: LW] = LW'(base + i);
    return d;
  endfunction

  // Driver: optional random idle cycles, then hold the beat until accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input int idle_pct);
    int n;
    logic [DW-1:0] res;
    while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
      s_tvalid = 1'b0;
      @(posedge aclk); #1;
    end
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    n = 0;
    while (!s_tready && n < 2000) begin
      @(posedge aclk); #1;
      n++;
    end
    if (!s_tready) begin
      checks++;
      $display("FAIL send_timeout: s_axis_tready=%0b after %0d cycles, required 1", s_tready, n);
      s_tvalid = 1'b0;
      return;
    end
    if (tb_start) begin
      tb_op = ctrl_op;
      tb_c  = ctrl_constant;
    end
    for (int i = 0; i < LANES; i++) res[i*LW +: LW] = ref_lane(tb_op, tb_c, d[i*LW +: LW]);
    exp_q.push_back({l, k, res});
    tb_start = l;
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
  endtask

  // Collector: records output handshakes. mode 0 ready=1, 1 random 50%, 2 stalled 100 cycles.
  task automatic collect(input int n, input int mode, input int max_cyc);
    int cyc;
    cyc = 0;
    got_q.delete();
    while (got_q.size() < n && cyc < max_cyc) begin
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(1));
        default: m_tready = (cyc >= 100);
      endcase
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tkeep, m_tdata});
      @(posedge aclk); #1;
      cyc++;
    end
    m_tready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    m_tready = 1'b0; ctrl_op = 2'd0; ctrl_constant = '0;
    repeat (3) @(posedge aclk); #1;
    checks++; if ({s_tready, m_tvalid, m_tlast} !== 3'b000)
      $display("FAIL reset_flags: tready/tvalid/tlast=%b required 000", {s_tready, m_tvalid, m_tlast});
    else passed++;
    checks++; if ({m_tdata, m_tkeep} !== '0) $display("FAIL reset_data: %h required 0", m_tdata);
    else passed++;
    checks++; if ({stat_beats, stat_packets, busy} !== '0)
      $display("FAIL reset_stats: beats=%0d packets=%0d busy=%0b required 0", stat_beats, stat_packets, busy);
    else passed++;
    areset = 1'b0;
    tb_start = 1'b1;
    @(posedge aclk); #1;
    checks++; if (s_tready !== 1'b1) $display("FAIL reset_release_ready: %b required 1", s_tready);
    else passed++;
  endtask

  task automatic test_latency();
    exp_q.delete();
    ctrl_op = 2'd2; ctrl_constant = '0;
    send_beat(rand_data(), '1, 1'b1, 0);
    checks++; if (m_tvalid !== 1'b0) $display("FAIL lat_n: m_tvalid=%b required 0", m_tvalid);
    else passed++;
    @(posedge aclk); #1;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL lat_n1: m_tvalid=%b required 0", m_tvalid);
    else passed++;
    @(posedge aclk); #1;
    checks++; if (m_tvalid !== 1'b1) $display("FAIL lat_n2: m_tvalid=%b required 1", m_tvalid);
    else passed++;
    collect(1, 0, 50);
    checks++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0])
      $display("FAIL lat_beat: got %0d beats, required 1 matching %h", got_q.size(), exp_q[0]);
    else passed++;
  endtask

  task automatic test_add();
    int pk0;
    logic [EW-1:0] b;
    exp_q.delete();
    pk0 = int'(stat_packets);
    ctrl_op = 2'd0; ctrl_constant = 32'd5;
    fork
      for (int i = 0; i < 4; i++) send_beat(ramp_data(0), '1, 1'(i == 3), 0);
      collect(4, 0, 200);
    join
    checks++; if (got_q.size() !== exp_q.size())
      $display("FAIL add_count: got %0d required %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL add_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    b = (got_q.size() == 4) ? got_q[3] : '0;
    checks++; if (b[15*LW +: LW] !== 32'd20 || b[0 +: LW] !== 32'd5 || b[EW-1] !== 1'b1)
      $display("FAIL add_lanes: lane0=%0d lane15=%0d last=%b required 5 20 1", b[0 +: LW], b[15*LW +: LW], b[EW-1]);
    else passed++;
    checks++; if (int'(stat_packets) - pk0 !== 1)
      $display("FAIL add_packets: delta %0d required 1", int'(stat_packets) - pk0);
    else passed++;
  endtask

  task automatic test_sub_boundary();
    logic [EW-1:0] b;
`ifdef VADD_LANE_ALU_SAT_EN
    int se0;
    se0 = int'(stat_sat_events);
`endif
    exp_q.delete();
    ctrl_op = 2'd1; ctrl_constant = 32'd1;
    fork
      send_beat('0, '1, 1'b1, 0);
      collect(1, 0, 50);
    join
    b = (got_q.size() == 1) ? got_q[0] : '0;
    checks++; if (got_q.size() !== 1 || b !== exp_q[0])
      $display("FAIL sub_model: got %h required %h", b, exp_q[0]);
    else passed++;
`ifdef VADD_LANE_ALU_SAT_EN
    checks++; if (b[0 +: LW] !== 32'h0) $display("FAIL sub_lane0: %h required 00000000", b[0 +: LW]);
    else passed++;
    checks++; if (int'(stat_sat_events) - se0 !== 1)
      $display("FAIL sat_events: delta %0d required 1", int'(stat_sat_events) - se0);
    else passed++;
`else
    checks++; if (b[0 +: LW] !== 32'hFFFF_FFFF) $display("FAIL sub_lane0: %h required ffffffff", b[0 +: LW]);
    else passed++;
`endif
  endtask

  task automatic test_op_latch();
    logic [EW-1:0] b7, b8;
    exp_q.delete();
    ctrl_op = 2'd0; ctrl_constant = 32'd10;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i == 2) ctrl_op = 2'd3;
          send_beat(ramp_data(i), $urandom, 1'(i == 7), 0);
        end
        send_beat(ramp_data(0), '1, 1'b1, 0);
      end
      collect(9, 0, 300);
    join
    checks++; if (got_q.size() !== exp_q.size())
      $display("FAIL latch_count: got %0d required %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL latch_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    b7 = (got_q.size() == 9) ? got_q[7] : '0;
    b8 = (got_q.size() == 9) ? got_q[8] : '0;
    checks++; if (b7[3*LW +: LW] !== 32'd20 || b8[3*LW +: LW] !== 32'd7)
      $display("FAIL latch_lane3: beat7=%0d beat8=%0d required 20 7", b7[3*LW +: LW], b8[3*LW +: LW]);
    else passed++;
  endtask

  task automatic test_backpressure();
    int bt0;
    exp_q.delete();
    bt0 = int'(stat_beats);
    ctrl_op = 2'd0; ctrl_constant = 32'd1;
    fork
      for (int i = 0; i < 60; i++) send_beat(rand_data(), $urandom, 1'(i % 10 == 9), 0);
      collect(60, 2, 3000);
      begin
        repeat (95) @(posedge aclk); #1;
        checks++; if (s_tready !== 1'b0) $display("FAIL bp_ready: %b required 0", s_tready);
        else passed++;
        checks++; if (int'(stat_beats) - bt0 !== DEPTH - 2)
          $display("FAIL bp_buffered: %0d required %0d", int'(stat_beats) - bt0, DEPTH - 2);
        else passed++;
      end
    join
    checks++; if (got_q.size() !== exp_q.size())
      $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    checks++; if (int'(stat_beats) - bt0 !== 60)
      $display("FAIL bp_stat_beats: delta %0d required 60", int'(stat_beats) - bt0);
    else passed++;
  endtask

  task automatic test_random();
    int bt0, pk0, npk;
    logic l;
    exp_q.delete();
    bt0 = int'(stat_beats); pk0 = int'(stat_packets); npk = 0;
    ctrl_op = 2'd3; ctrl_constant = 32'h8000_0000;
    fork
      for (int i = 0; i < 1000; i++) begin
        l = (i == 999) || ($urandom_range(7) == 0);
        if (l) npk++;
        send_beat(rand_data(), $urandom, l, 50);
      end
      collect(1000, 1, 20000);
    join
    checks++; if (got_q.size() !== exp_q.size())
      $display("FAIL rnd_count: got %0d required %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rnd_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    checks++; if (int'(stat_beats) - bt0 !== 1000 || int'(stat_packets) - pk0 !== npk)
      $display("FAIL rnd_stats: beats %0d packets %0d required 1000 %0d",
               int'(stat_beats) - bt0, int'(stat_packets) - pk0, npk);
    else passed++;
    repeat (3) @(posedge aclk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL rnd_idle_busy: %b required 0", busy);
    else passed++;
  endtask

  task automatic test_reset_midpacket();
    logic [EW-1:0] b;
    exp_q.delete();
    ctrl_op = 2'd0; ctrl_constant = 32'd3;
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(rand_data(), '1, 1'b0, 0);
    ctrl_op = 2'd1;
    #2 areset = 1'b1;
    #1;
    checks++; if ({m_tvalid, s_tready, busy} !== 3'b000 || m_tdata !== '0)
      $display("FAIL mid_reset_outputs: tvalid/tready/busy=%b data=%h required 000 and 0",
               {m_tvalid, s_tready, busy}, m_tdata);
    else passed++;
    checks++; if ({stat_beats, stat_packets} !== '0)
      $display("FAIL mid_reset_stats: beats=%0d packets=%0d required 0", stat_beats, stat_packets);
    else passed++;
    repeat (2) @(posedge aclk); #1;
    areset = 1'b0;
    exp_q.delete();
    tb_start = 1'b1;
    fork
      begin
        send_beat(ramp_data(100), '1, 1'b0, 0);
        send_beat(ramp_data(200), '1, 1'b1, 0);
      end
      collect(2, 0, 100);
    join
    checks++; if (got_q.size() !== 2) $display("FAIL mid_post_count: got %0d required 2", got_q.size());
    else passed++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL mid_post_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    b = (got_q.size() == 2) ? got_q[0] : '0;
    checks++; if (b[0 +: LW] !== 32'd97 || stat_beats !== 32'd2)
      $display("FAIL mid_post_op: lane0=%0d beats=%0d required 97 2", b[0 +: LW], stat_beats);
    else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_add();
    test_sub_boundary();
    test_op_latch();
    test_backpressure();
    test_random();
    test_reset_midpacket();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
